// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Issues one decoded ALU operation per request handshake, captures the
//            ALU result and returns it over a valid/ready response channel.
//            Optional feature macro: ALU_BRANCH_EVAL_EN (beq/bne taken output).
// Revision : 1.0
// ============================================================================
module alu_issue_unit #(
    parameter int         CNT_WIDTH    = 16,
    parameter logic [3:0] ILLEGAL_CODE = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_alu_op,
    input  logic [2:0]           req_funct3,
    input  logic                 req_funct7_5,
    input  logic                 req_op_imm,
    input  logic [31:0]          req_src1,
    input  logic [31:0]          req_src2,
    output logic [31:0]          alu_input1,
    output logic [31:0]          alu_input2,
    output logic [3:0]           ALUControl,
    input  logic [31:0]          alu_result,
    input  logic                 zero_flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal,
    output logic [CNT_WIDTH-1:0] op_count
`ifdef ALU_BRANCH_EVAL_EN
    ,
    output logic                 rsp_branch_taken
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [31:0]          in1_q, in2_q;
    logic [3:0]           ctrl_q;
    logic                 illegal_q;
    logic [31:0]          rsp_result_q;
    logic                 rsp_zero_q;
    logic                 rsp_illegal_q;
    logic [CNT_WIDTH-1:0] op_count_q;

    logic [3:0]           dec_ctrl;
    logic                 dec_illegal;
    logic                 req_fire;
    logic                 rsp_fire;

`ifdef ALU_BRANCH_EVAL_EN
    logic dec_branch, dec_bne;
    logic branch_q, bne_q, taken_q;
`endif

    // Decode ALUOp / funct3 / funct7[5] into the ALU control code.
    always_comb begin
        dec_ctrl    = ILLEGAL_CODE;
        dec_illegal = 1'b1;
`ifdef ALU_BRANCH_EVAL_EN
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
`endif
        case (req_alu_op)
            2'b00: begin
                dec_ctrl    = 4'b0010;
                dec_illegal = 1'b0;
            end
            2'b01: begin
`ifdef ALU_BRANCH_EVAL_EN
                if (req_funct3 == 3'b000 || req_funct3 == 3'b001) begin
                    dec_ctrl    = 4'b0110;
                    dec_illegal = 1'b0;
                    dec_branch  = 1'b1;
                    dec_bne     = req_funct3[0];
                end
`else
                dec_ctrl    = 4'b0110;
                dec_illegal = 1'b0;
`endif
            end
            2'b10: begin
                case (req_funct3)
                    3'b000: begin
                        dec_ctrl    = (req_funct7_5 && !req_op_imm) ? 4'b0110 : 4'b0010;
                        dec_illegal = 1'b0;
                    end
                    3'b111: begin
                        dec_ctrl    = 4'b0000;
                        dec_illegal = 1'b0;
                    end
                    3'b110: begin
                        dec_ctrl    = 4'b0001;
                        dec_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
    end

    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_q         <= '0;
            in2_q         <= '0;
            ctrl_q        <= 4'b0000;
            illegal_q     <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            op_count_q    <= '0;
`ifdef ALU_BRANCH_EVAL_EN
            branch_q      <= 1'b0;
            bne_q         <= 1'b0;
            taken_q       <= 1'b0;
`endif
        end else begin
            if (req_fire) begin
                in1_q     <= req_src1;
                in2_q     <= req_src2;
                ctrl_q    <= dec_ctrl;
                illegal_q <= dec_illegal;
`ifdef ALU_BRANCH_EVAL_EN
                branch_q  <= dec_branch;
                bne_q     <= dec_bne;
`endif
            end
            // Illegal requests report a zero result regardless of what the ALU drives.
            if (state_q == ST_EXEC) begin
                rsp_result_q  <= illegal_q ? 32'd0 : alu_result;
                rsp_zero_q    <= illegal_q ? 1'b1  : zero_flag;
                rsp_illegal_q <= illegal_q;
`ifdef ALU_BRANCH_EVAL_EN
                taken_q       <= branch_q & (bne_q ? ~zero_flag : zero_flag);
`endif
            end
            if (rsp_fire && (op_count_q != '1))
                op_count_q <= op_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign alu_input1  = in1_q;
    assign alu_input2  = in2_q;
    assign ALUControl  = ctrl_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;
`ifdef ALU_BRANCH_EVAL_EN
    assign rsp_branch_taken = taken_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Scoreboard bench for alu_issue_unit with a behavioural ALU and model.
// Revision : 1.0
// ============================================================================
module tb_alu_issue_unit;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [1:0]    req_alu_op;
    logic [2:0]    req_funct3;
    logic          req_funct7_5, req_op_imm;
    logic [31:0]   req_src1, req_src2;
    logic [31:0]   alu_input1, alu_input2;
    logic [3:0]    ALUControl;
    logic [31:0]   alu_result;
    logic          zero_flag;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_result;
    logic          rsp_zero, rsp_illegal;
    logic [CW-1:0] op_count;
`ifdef ALU_BRANCH_EVAL_EN
    logic          rsp_branch_taken;
`endif

    always #5 clk = ~clk;

    alu_issue_unit #(.CNT_WIDTH(CW), .ILLEGAL_CODE(4'b1111)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3),
        .req_funct7_5(req_funct7_5), .req_op_imm(req_op_imm),
        .req_src1(req_src1), .req_src2(req_src2),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .ALUControl(ALUControl),
        .alu_result(alu_result), .zero_flag(zero_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .op_count(op_count)
`ifdef ALU_BRANCH_EVAL_EN
        , .rsp_branch_taken(rsp_branch_taken)
`endif
    );

    // Behavioural ALU: add/sub/and/or, zero for anything else.
    always_comb begin
        case (ALUControl)
            4'b0010: alu_result = alu_input1 + alu_input2;
            4'b0110: alu_result = alu_input1 - alu_input2;
            4'b0000: alu_result = alu_input1 & alu_input2;
            4'b0001: alu_result = alu_input1 | alu_input2;
            default: alu_result = 32'd0;
        endcase
        zero_flag = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        tk;
    } rsp_t;

    rsp_t        sb[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, acc_cyc = 0, n_done = 0;
    bit          outstanding = 0, hold_rsp = 0, mon_en = 0, prev_valid = 0;
    logic [3:0]  last_ctrl = 4'b0000;
    logic [31:0] last_a = 32'd0, last_b = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: operation chosen from the decode rules, then evaluated arithmetically.
    function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                  input logic imm, input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] ctrl, output rsp_t r);
        int kind = 4;  // 0 add, 1 sub, 2 and, 3 or, 4 illegal
        bit beq = 0, bne = 0;
        if (op == 2'd0) kind = 0;
        else if (op == 2'd1) begin
`ifdef ALU_BRANCH_EVAL_EN
            if (f3 == 3'd0) begin kind = 1; beq = 1; end
            else if (f3 == 3'd1) begin kind = 1; bne = 1; end
`else
            kind = 1;
`endif
        end else if (op == 2'd2) begin
            if (f3 == 3'd0)      kind = (f7 && !imm) ? 1 : 0;
            else if (f3 == 3'd7) kind = 2;
            else if (f3 == 3'd6) kind = 3;
        end
        case (kind)
            0:       begin r.res = a + b; ctrl = 4'b0010; end
            1:       begin r.res = a - b; ctrl = 4'b0110; end
            2:       begin r.res = a & b; ctrl = 4'b0000; end
            3:       begin r.res = a | b; ctrl = 4'b0001; end
            default: begin r.res = 32'd0; ctrl = 4'b1111; end
        endcase
        r.ill = (kind == 4);
        r.z   = (r.res == 32'd0);
        r.tk  = beq ? r.z : (bne ? !r.z : 1'b0);
    endfunction

    function automatic int sat(input int n);
        return (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic imm, input logic [31:0] a, input logic [31:0] b);
        int   n = 0;
        rsp_t r;
        logic [3:0] ec;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            // Noise on the request port while it is not ready must be ignored.
            req_valid  = 1'($urandom);
            req_alu_op = 2'($urandom);
            req_funct3 = 3'($urandom);
            req_src1   = $urandom;
            req_src2   = $urandom;
            n++;
            if (n > 100) begin
                chk("req_ready_timeout", 32'd0, 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b1; req_alu_op = op; req_funct3 = f3;
        req_funct7_5 = f7; req_op_imm = imm; req_src1 = a; req_src2 = b;
        acc_cyc = cyc;
        model(op, f3, f7, imm, a, b, ec, r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb.push_back(r);
        outstanding = 1;
        last_ctrl = ec; last_a = a; last_b = b;
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: checks steady-state outputs each cycle and pops the scoreboard on handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("req_ready", 32'(req_ready), 32'(!outstanding));
                chk("op_count", 32'(op_count), 32'(sat(n_done)));
                chk("alu_ctrl", 32'(ALUControl), 32'(last_ctrl));
                chk("alu_in1", alu_input1, last_a);
                chk("alu_in2", alu_input2, last_b);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb[0];
                        if (!prev_valid) chk("latency", 32'(cyc - acc_cyc), 32'd2);
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", 32'(rsp_zero), 32'(e.z));
                        chk("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
`ifdef ALU_BRANCH_EVAL_EN
                        chk("rsp_taken", 32'(rsp_branch_taken), 32'(e.tk));
`endif
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            n_done++;
                            outstanding = 0;
                        end
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 200 && outstanding; i++) @(negedge clk);
        chk("drain", 32'(outstanding), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b0; req_alu_op = 2'd0; req_funct3 = 3'd0;
        req_funct7_5 = 1'b0; req_op_imm = 1'b0; req_src1 = 32'd0; req_src2 = 32'd0;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ctrl", 32'(ALUControl), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        issue(2'd2, 3'd0, 1'b0, 1'b0, 32'd5, 32'd7);
        issue(2'd2, 3'd0, 1'b1, 1'b0, 32'd9, 32'd9);
        issue(2'd2, 3'd0, 1'b1, 1'b1, 32'd9, 32'd9);
        issue(2'd2, 3'd4, 1'b0, 1'b0, 32'd3, 32'd3);
        issue(2'd2, 3'd7, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(2'd2, 3'd6, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        issue(2'd0, 3'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
        issue(2'd1, 3'd1, 1'b0, 1'b0, 32'd3, 32'd4);
        issue(2'd1, 3'd0, 1'b0, 1'b0, 32'd6, 32'd6);
        issue(2'd1, 3'd3, 1'b0, 1'b0, 32'd8, 32'd2);
        issue(2'd3, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2);
        drain();

        // Response backpressure with a pending request on the input.
        hold_rsp = 1;
        issue(2'd0, 3'd0, 1'b0, 1'b0, 32'd100, 32'd23);
        repeat (7) begin
            @(negedge clk);
            req_valid = 1'b1; req_alu_op = 2'($urandom); req_funct3 = 3'($urandom);
            req_src1 = $urandom; req_src2 = $urandom;
        end
        hold_rsp = 0;
        drain();
        req_valid = 1'b0;

        repeat (60) begin
            a = $urandom;
            issue(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), a,
                  ($urandom_range(0, 3) == 0) ? a : $urandom);
        end
        drain();

        // Asynchronous reset while a response is waiting.
        hold_rsp = 1;
        issue(2'd2, 3'd7, 1'b0, 1'b0, 32'hFFFF_0000, 32'h1234_5678);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("resp_before_reset", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ctrl", 32'(ALUControl), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_result", rsp_result, 32'd0);
        chk("mid_rst_in1", alu_input1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        outstanding = 0; n_done = 0; prev_valid = 0; hold_rsp = 0;
        last_ctrl = 4'b0000; last_a = 32'd0; last_b = 32'd0;
        mon_en = 1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        issue(2'd2, 3'd0, 1'b0, 1'b1, 32'd40, 32'd2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
